tile_transpose_writer: RTL and testbench

- Downstream stage of the 8x8 tile loader.
- Accepts one 8x8 tile of DW-bit words as a row-major serial stream and buffers it internally.
- Writes the tile back to SRAM in transposed (column-major) order, starting at a latched base address.
- Pulses done once the 64th write is accepted; the tile controller then issues the next start.

---
 rtl/tile_transpose_writer.sv | 85 ++++++++
 tb/tb_tile_transpose_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_transpose_writer.sv
// Buffers one row-major 8x8 tile of DW-bit words and writes it back to SRAM in
// column-major order, starting at the base address latched when start is accepted.
module tile_transpose_writer #(
   parameter int AW = 18,
   parameter int DW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          w_en,
   output logic [AW-1:0] w_addr,
   output logic [DW-1:0] w_data,
   input  logic          w_ready,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [5:0]    lcnt;
   logic [5:0]    wcnt;
   logic [AW-1:0] base_q;
   logic [DW-1:0] tile_buf [0:7][0:7];
   logic          in_fire;
   logic          w_fire;

   // Handshakes: a word moves on in_valid && in_ready; a write retires on w_en && w_ready.
   assign in_fire = (state == LOAD) && in_valid;
   assign w_fire  = (state == WRITE) && w_ready;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    if (in_fire && (lcnt == 6'd63)) state_next = WRITE;
         WRITE:   if (w_fire && (wcnt == 6'd63)) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // Both counters are 6 bits, so the 64th increment returns them to 0 for the next tile.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         lcnt   <= 6'd0;
         wcnt   <= 6'd0;
         base_q <= '0;
      end else begin
         state <= state_next;
         if ((state == IDLE) && start) base_q <= base_addr;
         if (in_fire) lcnt <= lcnt + 6'd1;
         if (w_fire) wcnt <= wcnt + 6'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (in_fire) tile_buf[lcnt[5:3]][lcnt[2:0]] <= in_data;
   end

   // Column-major read: low wcnt bits pick the row, high bits pick the column.
   always_comb begin
      in_ready = 1'b0;
      w_en     = 1'b0;
      w_addr   = '0;
      w_data   = '0;
      busy     = (state != IDLE);
      done     = (state == DONE);
      if (state == LOAD) in_ready = 1'b1;
      if (state == WRITE) begin
         w_en   = 1'b1;
         w_addr = base_q + {{(AW-6){1'b0}}, wcnt};
         w_data = tile_buf[wcnt[2:0]][wcnt[5:3]];
      end
   end

endmodule

// File: tb/tb_tile_transpose_writer.sv
// Bench for tile_transpose_writer: table of tile scenarios plus a mid-write reset
// sequence, with a write scoreboard fed from the expected transposed tile.
module tb_tile_transpose_writer;

   localparam int AW = 18;
   localparam int DW = 16;
   localparam int SW = AW + DW;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          w_en;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic          w_ready;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [SW-1:0] exp_q[$];
   logic [DW-1:0] tile [64];

   typedef struct {
      logic [AW-1:0] base;
      int stall_mode;     // 0 steady, 1 toggle 1,0,1,0, 2 random
      int bp_wcnt;
      int bp_len;
      int wr_rand;
      int rand_data;
      int ign_cyc;        // cycle at which a stray start is pulsed (0 = none)
      int exp_done;       // 0 = derive from model only
      int exp_first_wen;
   } vec_t;

   vec_t vecs[6];
   vec_t v_abort;
   vec_t v_fresh;

   tile_transpose_writer #(.AW(AW), .DW(DW)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .w_en      (w_en),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .w_ready   (w_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, {26'd0, in_ready, w_en, busy, done, w_addr, w_data}, 64'd0);
   endtask

   // Scoreboard: every accepted write is compared to the next expected {addr, data}.
   always @(negedge clock) begin
      if (!reset && w_en && w_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write actual=%0h/%0h required=none", w_addr, w_data);
         end else begin
            check("write_addr_data", {30'd0, w_addr, w_data}, {30'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic run_tile(input vec_t v, input int abort_at);
      int cyc = 0;
      int sent = 0;
      int wr_cnt = 0;
      int idle_in = 0;
      int stall_w = 0;
      int first_wen = 0;
      int done_cyc = 0;
      int bp_used = 0;
      int at_bp = 0;
      int hold_err = 0;
      int rdy_err = 0;
      int done_cnt = 0;
      logic prev_stall = 1'b0;
      logic [AW-1:0] prev_addr = '0;
      logic [DW-1:0] prev_data = '0;
      logic [AW-1:0] a;
      for (int i = 0; i < 64; i++) tile[i] = (v.rand_data != 0) ? DW'($urandom) : DW'(i);
      for (int k = 0; k < 64; k++) begin
         a = v.base + AW'(k);
         exp_q.push_back({a, tile[(k % 8) * 8 + k / 8]});
      end
      @(posedge clock);
      #1;
      start = 1'b1;
      base_addr = v.base;
      in_valid = 1'b0;
      w_ready = 1'b1;
      cyc = 1;
      while (done_cyc == 0 && cyc < 1000) begin
         @(negedge clock);
         if (w_en && first_wen == 0) first_wen = cyc;
         if (done) done_cyc = cyc;
         if (busy && sent < 64 && !in_ready) rdy_err++;
         if (in_ready && !in_valid) idle_in++;
         if (in_ready && in_valid) sent++;
         if (w_en && !w_ready) stall_w++;
         if (prev_stall && (!w_en || w_addr != prev_addr || w_data != prev_data)) hold_err++;
         prev_stall = w_en && !w_ready;
         prev_addr = w_addr;
         prev_data = w_data;
         if (w_en && wr_cnt == v.bp_wcnt) at_bp++;
         if (w_en && w_ready) wr_cnt++;
         @(posedge clock);
         #1;
         cyc++;
         start = (cyc == v.ign_cyc);
         base_addr = start ? 18'h00200 : AW'($urandom);
         if (sent >= 64) in_valid = 1'($urandom_range(0, 1));
         else if (v.stall_mode == 1) in_valid = (cyc % 2 == 0);
         else if (v.stall_mode == 2) in_valid = 1'($urandom_range(0, 1));
         else in_valid = 1'b1;
         in_data = (sent < 64) ? tile[sent] : DW'($urandom);
         if (v.bp_len > 0 && wr_cnt == v.bp_wcnt && bp_used < v.bp_len) begin
            w_ready = 1'b0;
            bp_used++;
         end else if (v.wr_rand != 0) w_ready = ($urandom_range(0, 3) != 0);
         else w_ready = 1'b1;
         if (abort_at >= 0 && wr_cnt == abort_at) begin
            reset = 1'b1;
            start = 1'b0;
            in_valid = 1'b0;
            #1 check_zero("abort_reset_outputs");
            @(negedge clock);
            check_zero("abort_reset_hold");
            @(posedge clock);
            #1 reset = 1'b0;
            exp_q.delete();
            repeat (4) begin
               @(negedge clock);
               if (done || busy) done_cnt++;
            end
            check("abort_no_done", done_cnt, 0);
            return;
         end
      end
      start = 1'b0;
      in_valid = 1'b0;
      w_ready = 1'b1;
      check("done_cycle_model", done_cyc, 130 + idle_in + stall_w);
      if (v.exp_done != 0) check("done_cycle_table", done_cyc, v.exp_done);
      check("first_wen_model", first_wen, 66 + idle_in);
      if (v.exp_first_wen != 0) check("first_wen_table", first_wen, v.exp_first_wen);
      check("write_count", wr_cnt, 64);
      check("scoreboard_empty", exp_q.size(), 0);
      check("w_hold_stable", hold_err, 0);
      check("in_ready_in_load", rdy_err, 0);
      if (v.bp_len > 0) check("bp_hold_cycles", at_bp, v.bp_len + 1);
      @(negedge clock);
      check("busy_done_after", {busy, done}, 2'b00);
      exp_q.delete();
   endtask

   initial begin
      vecs[0] = '{18'h00100, 0, 0, 0, 0, 0, 0, 130, 66};
      vecs[1] = '{18'h00100, 1, 0, 0, 0, 0, 0, 193, 129};
      vecs[2] = '{18'h00100, 0, 5, 3, 0, 0, 0, 133, 66};
      vecs[3] = '{18'h3FFFC, 0, 0, 0, 0, 1, 0, 130, 66};
      vecs[4] = '{18'h00100, 0, 0, 0, 0, 1, 20, 130, 66};
      vecs[5] = '{18'h2A5A0, 2, 0, 0, 1, 1, 0, 0, 0};
      v_abort = '{18'h00500, 0, 0, 0, 0, 1, 0, 0, 0};
      v_fresh = '{18'h00040, 0, 0, 0, 0, 1, 0, 130, 66};

      reset = 1'b1;
      start = 1'b0;
      base_addr = '0;
      in_valid = 1'b0;
      in_data = '0;
      w_ready = 1'b0;
      @(negedge clock);
      check_zero("reset_state");
      @(posedge clock);
      #1 reset = 1'b0;
      in_valid = 1'b1;
      in_data = 16'hBEEF;
      repeat (3) begin
         @(negedge clock);
         check("idle_ignores_in_valid", {in_ready, busy, w_en}, 3'b000);
      end
      in_valid = 1'b0;

      for (int t = 0; t < 6; t++) run_tile(vecs[t], -1);

      run_tile(v_abort, 20);
      run_tile(v_fresh, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
